uart_tx_buffered: RTL and testbench

// - Buffered UART transmitter (8N1): accepts bytes from fabric logic into a FIFO and serialises them onto tx back-to-back.
// - Serves as the outbound path next to the existing UART receiver. Lets producers burst several bytes without waiting on line rate.
// - Example producers: a command responder or a status dumper.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 92 +++++++++
 rtl/uart_tx_buffered.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Contents: data width, default bit period, serialiser state type and
// a helper that sizes the per-bit clock counter.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS       = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Width of a counter that spans 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   push, wdata   : write strobe and data (ignored when full and not popping)
//   pop           : consume head entry (ignored when empty)
//   rdata         : head entry, valid whenever empty is low
//   count         : entries held (registered)
//   full, empty   : registered flags derived from the entry count
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             pop_ok_c;
  logic             push_ok_c;

  // Pointer, count and flag update; pointers wrap naturally (DEPTH is a power of 2).
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pop_ok_c  = pop && !empty_q;
    // A full FIFO can still take a write when the head leaves on the same edge.
    push_ok_c = push && (!full_q || pop_ok_c);

    if (push_ok_c) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push_ok_c, pop_ok_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Control state with synchronous reset; contents are simply abandoned on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes are queued in a FIFO and sent
// back-to-back on tx, LSB first.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   i_wr_en, i_wr_data    : byte write into the FIFO
//   o_full, o_empty       : FIFO flags
//   o_count               : bytes currently queued
//   o_overflow            : one-cycle pulse when a write is dropped
//   o_busy                : serialiser is inside a frame
//   o_tx_done             : one-cycle pulse on the last stop-bit cycle
//   tx                    : registered serial line, idle high
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned clks_per_bit = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_wr_en,
  input  logic [UART_DATA_BITS-1:0]     i_wr_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_overflow,
  output logic                          o_busy,
  output logic                          o_tx_done,
  output logic                          tx
);

  localparam int unsigned CNT_W = cnt_width(clks_per_bit);
  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);

  tx_state_e                  state_q, state_d;
  logic [CNT_W-1:0]           clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]           bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
  logic                       tx_q, tx_d;
  logic                       busy_q, busy_d;
  logic                       tx_done_q, tx_done_d;
  logic                       overflow_q, overflow_d;

  logic                       pop_c;
  logic                       push_c;
  logic                       bit_end_c;
  logic [UART_DATA_BITS-1:0]  fifo_rdata;
  logic                       fifo_full;
  logic                       fifo_empty;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (i_wr_data),
    .rdata (fifo_rdata),
    .count (o_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Serialiser next state, FIFO pop and write acceptance.
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = 1'b1;
    tx_done_d  = 1'b0;
    pop_c      = 1'b0;
    bit_end_c  = (clk_cnt_q == CNT_W'(clks_per_bit - 1));

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = fifo_rdata;
          state_d = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          clk_cnt_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end_c) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          if (bit_idx_q == IDX_W'(UART_DATA_BITS - 1)) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end_c) begin
          clk_cnt_d = '0;
          tx_done_d = 1'b1;
          // Chain straight into the next start bit when more data is waiting.
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            shift_d = fifo_rdata;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
        bit_idx_d = '0;
      end
    endcase

    // Line level follows the current state, so tx lags the state by one edge.
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase

    busy_d     = (state_d != IDLE);
    push_c     = i_wr_en && (!fifo_full || pop_c);
    overflow_d = i_wr_en && !push_c;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx         = tx_q;
  assign o_busy     = busy_q;
  assign o_tx_done  = tx_done_q;
  assign o_overflow = overflow_q;
  assign o_full     = fifo_full;
  assign o_empty    = fifo_empty;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered (clks_per_bit=4, FIFO_DEPTH=4).
// A line monitor decodes tx mid-bit and checks each frame against a
// queue of expected bytes filled as writes are driven.
module tb_uart_tx_buffered;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_wr_en;
  logic [7:0] i_wr_data;
  logic       o_full;
  logic       o_empty;
  logic [2:0] o_count;
  logic       o_overflow;
  logic       o_busy;
  logic       o_tx_done;
  logic       tx;

  uart_tx_buffered #(
    .clks_per_bit (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (i_wr_en),
    .i_wr_data  (i_wr_data),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .o_busy     (o_busy),
    .o_tx_done  (o_tx_done),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  int         ovf_cnt = 0;
  int         last_start = -1;
  bit         ignore_line = 1'b0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       acc;
    logic [2:0] cnt;
    logic       ovf;
    logic       full;
    logic       empty;
  } vec_t;

  vec_t ovf_tab[7];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_tx_done === 1'b1) done_cnt++;
    if (o_overflow === 1'b1) ovf_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d, input bit expect_on_line);
    i_wr_en   = 1'b1;
    i_wr_data = d;
    if (expect_on_line) exp_q.push_back(d);
    step();
    i_wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string nm);
    int n;
    n = 0;
    while (!(o_busy === 1'b0 && o_empty === 1'b1 && exp_q.size() == 0) && n < max_cyc) begin
      step();
      n++;
    end
    checks++;
    if (n >= max_cyc) begin
      failures++;
      $display("FAIL %s_idle: got busy=%0b pending=%0d expected idle within %0d cycles",
               nm, o_busy, exp_q.size(), max_cyc);
      exp_q.delete();
    end
    repeat (3) step();
  endtask

  function automatic int start_at(input int idx);
    return (idx < start_q.size()) ? start_q[idx] : -1;
  endfunction

  // Line monitor: frame detected on the first low sample, then sampled mid-bit.
  initial begin : line_mon
    logic [7:0] b;
    bit         ign;
    int         s;
    b = '0;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        s   = cyc;
        ign = ignore_line;
        start_q.push_back(s);
        last_start = s;
        repeat (2) @(negedge clk);
        if (!ign) chk("start_bit", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (!ign) begin
          chk("stop_bit", 32'(tx), 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame: got 0x%02h expected no frame", b);
          end else begin
            chk("rx_byte", 32'(b), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 time units");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int s0;
    int d0;
    int o0;

    ovf_tab[0] = '{1'b1, 8'h10, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
    ovf_tab[1] = '{1'b1, 8'h11, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
    ovf_tab[2] = '{1'b1, 8'h12, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
    ovf_tab[3] = '{1'b1, 8'h13, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
    ovf_tab[4] = '{1'b1, 8'h14, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0};
    ovf_tab[5] = '{1'b1, 8'h15, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0};
    ovf_tab[6] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0};

    reset     = 1'b1;
    i_wr_en   = 1'b0;
    i_wr_data = 8'h00;
    repeat (3) step();

    chk("rst_tx",       32'(tx),         32'd1);
    chk("rst_busy",     32'(o_busy),     32'd0);
    chk("rst_tx_done",  32'(o_tx_done),  32'd0);
    chk("rst_overflow", 32'(o_overflow), 32'd0);
    chk("rst_count",    32'(o_count),    32'd0);
    chk("rst_empty",    32'(o_empty),    32'd1);
    chk("rst_full",     32'(o_full),     32'd0);

    reset = 1'b0;
    repeat (2) step();

    // Single byte and first-transaction latency.
    s0 = start_q.size();
    d0 = done_cnt;
    write_byte(8'hA5, 1'b1);
    n = cyc;
    chk("t1_count_after_write", 32'(o_count), 32'd1);
    chk("t1_empty_after_write", 32'(o_empty), 32'd0);
    chk("t1_tx_idle_n",         32'(tx),      32'd1);
    step();
    chk("t1_count_after_pop",   32'(o_count), 32'd0);
    chk("t1_busy_after_pop",    32'(o_busy),  32'd1);
    chk("t1_tx_idle_n1",        32'(tx),      32'd1);
    step();
    chk("t1_tx_low_n2",         32'(tx),      32'd0);
    wait_idle(100, "t1");
    chk("t1_start_latency",     32'(start_at(s0)), 32'(n + 2));
    chk("t1_done_pulses",       32'(done_cnt - d0), 32'd1);
    chk("t1_busy_end",          32'(o_busy),  32'd0);

    // Burst of three, back-to-back frames.
    s0 = start_q.size();
    d0 = done_cnt;
    write_byte(8'h01, 1'b1);
    write_byte(8'h02, 1'b1);
    write_byte(8'h03, 1'b1);
    wait_idle(300, "t2");
    chk("t2_gap_1_2", 32'(start_at(s0 + 1) - start_at(s0)), 32'd40);
    chk("t2_gap_2_3", 32'(start_at(s0 + 2) - start_at(s0 + 1)), 32'd40);
    chk("t2_span",    32'(start_at(s0 + 2) - start_at(s0) + 40), 32'd120);
    chk("t2_done_pulses", 32'(done_cnt - d0), 32'd3);

    // Overflow, table driven.
    o0 = ovf_cnt;
    for (int i = 0; i < 7; i++) begin
      i_wr_en   = ovf_tab[i].wr;
      i_wr_data = ovf_tab[i].data;
      if (ovf_tab[i].wr && ovf_tab[i].acc) exp_q.push_back(ovf_tab[i].data);
      step();
      chk($sformatf("t3_count_%0d", i),    32'(o_count),    32'(ovf_tab[i].cnt));
      chk($sformatf("t3_overflow_%0d", i), 32'(o_overflow), 32'(ovf_tab[i].ovf));
      chk($sformatf("t3_full_%0d", i),     32'(o_full),     32'(ovf_tab[i].full));
      chk($sformatf("t3_empty_%0d", i),    32'(o_empty),    32'(ovf_tab[i].empty));
    end
    i_wr_en = 1'b0;
    wait_idle(400, "t3");
    chk("t3_overflow_pulses", 32'(ovf_cnt - o0), 32'd1);

    // Full FIFO with a write landing on the final stop-bit cycle.
    o0 = ovf_cnt;
    write_byte(8'h40, 1'b1);
    n = cyc;
    write_byte(8'h41, 1'b1);
    write_byte(8'h42, 1'b1);
    write_byte(8'h43, 1'b1);
    write_byte(8'h44, 1'b1);
    chk("t4_count_filled", 32'(o_count), 32'd4);
    chk("t4_full_filled",  32'(o_full),  32'd1);
    while (cyc < n + 40) step();
    chk("t4_count_before", 32'(o_count), 32'd4);
    write_byte(8'h7E, 1'b1);
    chk("t4_edge",         32'(cyc),        32'(n + 41));
    chk("t4_count_after",  32'(o_count),    32'd4);
    chk("t4_overflow",     32'(o_overflow), 32'd0);
    chk("t4_busy",         32'(o_busy),     32'd1);
    step();
    chk("t4_overflow_next", 32'(o_overflow), 32'd0);
    wait_idle(500, "t4");
    chk("t4_no_overflow_pulse", 32'(ovf_cnt - o0), 32'd0);

    // Reset during data bit 3 with two bytes queued.
    ignore_line = 1'b1;
    write_byte(8'h3C, 1'b0);
    n = cyc;
    write_byte(8'h55, 1'b0);
    write_byte(8'h66, 1'b0);
    chk("t5_queued", 32'(o_count), 32'd2);
    while (cyc < n + 17) step();
    reset = 1'b1;
    step();
    chk("t5_tx_after_reset",    32'(tx),      32'd1);
    chk("t5_count_after_reset", 32'(o_count), 32'd0);
    chk("t5_busy_after_reset",  32'(o_busy),  32'd0);
    chk("t5_empty_after_reset", 32'(o_empty), 32'd1);
    reset = 1'b0;
    repeat (60) step();
    chk("t5_tx_quiet",    32'(tx),         32'd1);
    chk("t5_busy_quiet",  32'(o_busy),     32'd0);
    chk("t5_count_quiet", 32'(o_count),    32'd0);
    chk("t5_last_start",  32'(last_start), 32'(n + 2));
    ignore_line = 1'b0;

    // Edge data values.
    s0 = start_q.size();
    write_byte(8'h00, 1'b1);
    write_byte(8'hFF, 1'b1);
    wait_idle(300, "t6");
    chk("t6_frames", 32'(start_q.size() - s0), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
